// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_ctrl_pkg;

  localparam int unsigned FLUSH_DEPTH_MAX = 3;
  localparam int unsigned FWD_W           = 2;
  localparam int unsigned STATE_W         = 2;

  // Operand source selected for the instruction entering X.
  typedef enum logic [FWD_W-1:0] {
    FWD_NONE = 2'b00,
    FWD_XM   = 2'b01,
    FWD_MW   = 2'b10
  } fwd_sel_e;

  // Hazard controller state.
  typedef enum logic [STATE_W-1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } haz_state_e;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Per-operand forwarding comparator: nearest writing producer wins, r0 never forwards.
module hazard_fwd_cmp
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic [REG_AW-1:0] x_dst,
  input  logic              x_reg_write,
  input  logic [REG_AW-1:0] m_dst,
  input  logic              m_reg_write,
  output logic [1:0]        sel_c
);

  // XM result is younger than MW, so it is checked first.
  always_comb begin
    sel_c = FWD_NONE;
    if (use_src && x_reg_write && (x_dst == src) && (x_dst != '0)) begin
      sel_c = FWD_XM;
    end else if (use_src && m_reg_write && (m_dst == src) && (m_dst != '0)) begin
      sel_c = FWD_MW;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and flush controller for the 5-stage pipeline.
// Optional build macro: HAZARD_PERF_EN adds saturating stall/flush/wait counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned FLUSH_DEPTH = 3,
  parameter int unsigned PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] d_rs_a,
  input  logic [REG_AW-1:0] d_rt_a,
  input  logic              d_uses_rt,
  input  logic [REG_AW-1:0] x_dst,
  input  logic              x_reg_write,
  input  logic              x_mem_read,
  input  logic [REG_AW-1:0] m_dst,
  input  logic              m_reg_write,
  input  logic              m_mem_req,
  input  logic              mem_ready,
  input  logic              redirect,
  output logic              stall_if,
  output logic              stall_fd,
  output logic              stall_dx,
  output logic              stall_xm,
  output logic              bubble_dx,
  output logic              flush_fd,
  output logic              flush_dx,
  output logic              flush_xm,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic [1:0]        haz_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
  output logic [PERF_W-1:0] wait_cnt
`endif
);

  // Out-of-range depths are clamped into 1..FLUSH_DEPTH_MAX.
  localparam int unsigned FLUSH_D = (FLUSH_DEPTH > FLUSH_DEPTH_MAX) ? FLUSH_DEPTH_MAX :
                                    ((FLUSH_DEPTH < 1) ? 1 : FLUSH_DEPTH);

  if ((FLUSH_DEPTH < 1) || (FLUSH_DEPTH > FLUSH_DEPTH_MAX) || (PERF_W < 1)) begin : g_bad_param
    $error("hazard_ctrl: parameter out of range");
  end

  haz_state_e  state_q;
  haz_state_e  state_d;
  logic        mem_wait_c;
  logic        load_use_c;
  logic [1:0]  rs_sel_c;
  logic [1:0]  rt_sel_c;

  assign mem_wait_c = m_mem_req && !mem_ready;
  assign load_use_c = x_mem_read && x_reg_write && (x_dst != '0) &&
                      ((x_dst == d_rs_a) || (d_uses_rt && (x_dst == d_rt_a)));
  assign haz_state  = state_q;

  hazard_fwd_cmp #(.REG_AW(REG_AW)) u_cmp_rs (
    .src        (d_rs_a),
    .use_src    (1'b1),
    .x_dst      (x_dst),
    .x_reg_write(x_reg_write),
    .m_dst      (m_dst),
    .m_reg_write(m_reg_write),
    .sel_c      (rs_sel_c)
  );

  hazard_fwd_cmp #(.REG_AW(REG_AW)) u_cmp_rt (
    .src        (d_rt_a),
    .use_src    (d_uses_rt),
    .x_dst      (x_dst),
    .x_reg_write(x_reg_write),
    .m_dst      (m_dst),
    .m_reg_write(m_reg_write),
    .sel_c      (rt_sel_c)
  );

  // State register; reset abandons any wait immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Next state and same-cycle pipeline controls; priority is mem wait > redirect > load-use.
  always_comb begin
    state_d   = state_q;
    stall_if  = 1'b0;
    stall_fd  = 1'b0;
    stall_dx  = 1'b0;
    stall_xm  = 1'b0;
    bubble_dx = 1'b0;
    flush_fd  = 1'b0;
    flush_dx  = 1'b0;
    flush_xm  = 1'b0;
    if (!rst) begin
      state_d  = RUN;
      flush_fd = 1'b1;
      flush_dx = 1'b1;
      flush_xm = 1'b1;
    end else begin
      unique case (state_q)
        // The load reaches M during LOAD_STALL, so it may still start a memory wait there.
        RUN, LOAD_STALL: begin
          if (mem_wait_c) begin
            state_d  = MEM_WAIT;
            stall_if = 1'b1;
            stall_fd = 1'b1;
            stall_dx = 1'b1;
            stall_xm = 1'b1;
          end else if (redirect) begin
            state_d = FLUSH;
          end else if ((state_q == RUN) && load_use_c) begin
            state_d   = LOAD_STALL;
            stall_if  = 1'b1;
            stall_fd  = 1'b1;
            bubble_dx = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            stall_if = 1'b1;
            stall_fd = 1'b1;
            stall_dx = 1'b1;
            stall_xm = 1'b1;
          end else begin
            state_d = redirect ? FLUSH : RUN;
          end
        end
        FLUSH: begin
          flush_fd = 1'b1;
          flush_dx = (FLUSH_D >= 2);
          flush_xm = (FLUSH_D >= 3);
          state_d  = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Forward selects follow the instruction into DX; a bubble or flush carries no operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_rs_sel <= FWD_NONE;
      fwd_rt_sel <= FWD_NONE;
    end else if (bubble_dx || flush_dx) begin
      fwd_rs_sel <= FWD_NONE;
      fwd_rt_sel <= FWD_NONE;
    end else if (!stall_dx) begin
      fwd_rs_sel <= rs_sel_c;
      fwd_rt_sel <= rt_sel_c;
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating event counters; LOAD_STALL lasts one cycle so its cycles equal its entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if ((state_q == LOAD_STALL) && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_W'(1);
      if ((state_q == FLUSH) && (flush_cnt != '1))      flush_cnt <= flush_cnt + PERF_W'(1);
      if ((state_q == MEM_WAIT) && (wait_cnt != '1))    wait_cnt  <= wait_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: depth-3 (a) and depth-2 (b) instances share stimulus.
module tb_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned PERF_W = 16;

  logic clk = 1'b0;
  logic rst;
  logic [REG_AW-1:0] d_rs_a, d_rt_a, x_dst, m_dst;
  logic d_uses_rt, x_reg_write, x_mem_read, m_reg_write, m_mem_req, mem_ready, redirect;

  logic stall_if_a, stall_fd_a, stall_dx_a, stall_xm_a, bubble_dx_a, flush_fd_a, flush_dx_a, flush_xm_a;
  logic stall_if_b, stall_fd_b, stall_dx_b, stall_xm_b, bubble_dx_b, flush_fd_b, flush_dx_b, flush_xm_b;
  logic [1:0] fwd_rs_a, fwd_rt_a, st_a, fwd_rs_b, fwd_rt_b, st_b;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_a, flush_cnt_a, wait_cnt_a, stall_cnt_b, flush_cnt_b, wait_cnt_b;
`endif

  logic [7:0] ctl_a, ctl_b;
  assign ctl_a = {stall_if_a, stall_fd_a, stall_dx_a, stall_xm_a, bubble_dx_a, flush_fd_a, flush_dx_a, flush_xm_a};
  assign ctl_b = {stall_if_b, stall_fd_b, stall_dx_b, stall_xm_b, bubble_dx_b, flush_fd_b, flush_dx_b, flush_xm_b};

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  hazard_ctrl #(.REG_AW(REG_AW), .FLUSH_DEPTH(3), .PERF_W(PERF_W)) u_dut_a (
    .clk(clk), .rst(rst), .d_rs_a(d_rs_a), .d_rt_a(d_rt_a), .d_uses_rt(d_uses_rt),
    .x_dst(x_dst), .x_reg_write(x_reg_write), .x_mem_read(x_mem_read), .m_dst(m_dst),
    .m_reg_write(m_reg_write), .m_mem_req(m_mem_req), .mem_ready(mem_ready), .redirect(redirect),
    .stall_if(stall_if_a), .stall_fd(stall_fd_a), .stall_dx(stall_dx_a), .stall_xm(stall_xm_a),
    .bubble_dx(bubble_dx_a), .flush_fd(flush_fd_a), .flush_dx(flush_dx_a), .flush_xm(flush_xm_a),
    .fwd_rs_sel(fwd_rs_a), .fwd_rt_sel(fwd_rt_a), .haz_state(st_a)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a), .wait_cnt(wait_cnt_a)
`endif
  );

  hazard_ctrl #(.REG_AW(REG_AW), .FLUSH_DEPTH(2), .PERF_W(PERF_W)) u_dut_b (
    .clk(clk), .rst(rst), .d_rs_a(d_rs_a), .d_rt_a(d_rt_a), .d_uses_rt(d_uses_rt),
    .x_dst(x_dst), .x_reg_write(x_reg_write), .x_mem_read(x_mem_read), .m_dst(m_dst),
    .m_reg_write(m_reg_write), .m_mem_req(m_mem_req), .mem_ready(mem_ready), .redirect(redirect),
    .stall_if(stall_if_b), .stall_fd(stall_fd_b), .stall_dx(stall_dx_b), .stall_xm(stall_xm_b),
    .bubble_dx(bubble_dx_b), .flush_fd(flush_fd_b), .flush_dx(flush_dx_b), .flush_xm(flush_xm_b),
    .fwd_rs_sel(fwd_rs_b), .fwd_rt_sel(fwd_rt_b), .haz_state(st_b)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b), .wait_cnt(wait_cnt_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_rs_a = '0; d_rt_a = '0; d_uses_rt = 1'b0;
    x_dst = '0; x_reg_write = 1'b0; x_mem_read = 1'b0;
    m_dst = '0; m_reg_write = 1'b0; m_mem_req = 1'b0; mem_ready = 1'b1; redirect = 1'b0;
  endtask

  // Reference forwarding rule for one operand.
  function automatic logic [1:0] model_sel(input logic [REG_AW-1:0] src, input logic use_it,
                                           input logic [REG_AW-1:0] xd, input logic xw,
                                           input logic [REG_AW-1:0] md, input logic mw);
    if (!use_it) return 2'b00;
    if (xw && xd == src && xd != 0) return 2'b01;
    if (mw && md == src && md != 0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #2;
    checks++;
    if ({st_a, st_b} !== 4'b0000) begin errors++; $display("FAIL reset_state got %b exp 0000", {st_a, st_b}); end
    checks++;
    if ({ctl_a, ctl_b} !== 16'h0707) begin errors++; $display("FAIL reset_ctl got %h exp 0707", {ctl_a, ctl_b}); end
    checks++;
    if ({fwd_rs_a, fwd_rt_a, fwd_rs_b, fwd_rt_b} !== 8'h00) begin
      errors++; $display("FAIL reset_fwd got %h exp 00", {fwd_rs_a, fwd_rt_a, fwd_rs_b, fwd_rt_b});
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++;
    if ({st_a, ctl_a} !== 10'h000) begin errors++; $display("FAIL reset_release got %h exp 000", {st_a, ctl_a}); end
  endtask

  task automatic test_fwd_directed();
    logic [3:0] exp;
    // XM forward for rs
    idle(); x_dst = 5'd5; x_reg_write = 1'b1; d_rs_a = 5'd5;
    exp_q.push_back(4'b0100);
    step();
    exp = exp_q.pop_front();
    checks++;
    if ({fwd_rs_a, fwd_rt_a, fwd_rs_b, fwd_rt_b} !== {exp, exp}) begin
      errors++; $display("FAIL fwd_xm_rs got %b exp %b", {fwd_rs_a, fwd_rt_a, fwd_rs_b, fwd_rt_b}, {exp, exp});
    end
    // r0 never forwards
    idle(); x_dst = 5'd0; x_reg_write = 1'b1; d_rs_a = 5'd0;
    exp_q.push_back(4'b0000);
    step();
    exp = exp_q.pop_front();
    checks++;
    if ({fwd_rs_a, fwd_rt_a} !== exp) begin errors++; $display("FAIL fwd_r0 got %b exp %b", {fwd_rs_a, fwd_rt_a}, exp); end
    // XM beats MW on rt
    idle(); x_dst = 5'd7; x_reg_write = 1'b1; m_dst = 5'd7; m_reg_write = 1'b1; d_rt_a = 5'd7; d_uses_rt = 1'b1;
    exp_q.push_back(4'b0001);
    step();
    exp = exp_q.pop_front();
    checks++;
    if ({fwd_rs_a, fwd_rt_a} !== exp) begin errors++; $display("FAIL fwd_xm_beats_mw got %b exp %b", {fwd_rs_a, fwd_rt_a}, exp); end
    // rt ignored when unused; rs from MW
    idle(); m_dst = 5'd9; m_reg_write = 1'b1; d_rs_a = 5'd9; d_rt_a = 5'd9; d_uses_rt = 1'b0;
    exp_q.push_back(4'b1000);
    step();
    exp = exp_q.pop_front();
    checks++;
    if ({fwd_rs_a, fwd_rt_a} !== exp) begin errors++; $display("FAIL fwd_mw_rt_unused got %b exp %b", {fwd_rs_a, fwd_rt_a}, exp); end
  endtask

  task automatic test_fwd_random();
    logic [3:0] exp;
    for (int i = 0; i < 30; i++) begin
      idle();
      d_rs_a = REG_AW'($urandom_range(0, 3)); d_rt_a = REG_AW'($urandom_range(0, 3));
      d_uses_rt = 1'($urandom_range(0, 1));
      x_dst = REG_AW'($urandom_range(0, 3)); x_reg_write = 1'($urandom_range(0, 1));
      m_dst = REG_AW'($urandom_range(0, 3)); m_reg_write = 1'($urandom_range(0, 1));
      exp_q.push_back({model_sel(d_rs_a, 1'b1, x_dst, x_reg_write, m_dst, m_reg_write),
                       model_sel(d_rt_a, d_uses_rt, x_dst, x_reg_write, m_dst, m_reg_write)});
      step();
      if (exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL fwd_rand_queue_empty got 0 exp 1");
      end else begin
        exp = exp_q.pop_front();
        checks++;
        if ({fwd_rs_a, fwd_rt_a, st_a} !== {exp, 2'b00}) begin
          errors++; $display("FAIL fwd_rand[%0d] got %b exp %b", i, {fwd_rs_a, fwd_rt_a, st_a}, {exp, 2'b00});
        end
      end
    end
  endtask

  task automatic test_load_use();
    logic [3:0] exp;
    idle(); x_dst = 5'd3; x_reg_write = 1'b1; x_mem_read = 1'b1; d_rs_a = 5'd3;
    @(negedge clk);
    checks++;
    if ({st_a, ctl_a} !== {2'd0, 8'b11001000}) begin
      errors++; $display("FAIL load_use_detect got %b exp %b", {st_a, ctl_a}, {2'd0, 8'b11001000});
    end
    exp_q.push_back(4'b0000);
    step();
    exp = exp_q.pop_front();
    checks++;
    if ({st_a, fwd_rs_a, fwd_rt_a} !== {2'd1, exp}) begin
      errors++; $display("FAIL load_use_bubble got %b exp %b", {st_a, fwd_rs_a, fwd_rt_a}, {2'd1, exp});
    end
    // load now in M, bubble in X, dependent instruction still in D
    idle(); m_dst = 5'd3; m_reg_write = 1'b1; d_rs_a = 5'd3;
    exp_q.push_back(4'b1000);
    @(negedge clk);
    checks++;
    if (ctl_a !== 8'h00) begin errors++; $display("FAIL load_stall_ctl got %b exp 00000000", ctl_a); end
    step();
    exp = exp_q.pop_front();
    checks++;
    if ({st_a, fwd_rs_a, fwd_rt_a} !== {2'd0, exp}) begin
      errors++; $display("FAIL load_use_mw got %b exp %b", {st_a, fwd_rs_a, fwd_rt_a}, {2'd0, exp});
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cnt_a !== PERF_W'(1)) begin errors++; $display("FAIL stall_cnt got %0d exp 1", stall_cnt_a); end
`endif
  endtask

  task automatic test_mem_wait();
    idle(); m_mem_req = 1'b1; mem_ready = 1'b0; redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({st_a, ctl_a, ctl_b} !== {(i == 0) ? 2'd0 : 2'd2, 8'hF0, 8'hF0}) begin
        errors++; $display("FAIL mem_wait[%0d] got %h exp %h", i, {st_a, ctl_a, ctl_b}, {(i == 0) ? 2'd0 : 2'd2, 8'hF0, 8'hF0});
      end
      step();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({st_a, ctl_a} !== {2'd2, 8'h00}) begin errors++; $display("FAIL mem_ready_drop got %h exp 200", {st_a, ctl_a}); end
    step();
    idle();
    @(negedge clk);
    checks++;
    if ({st_a, st_b, ctl_a, ctl_b} !== {2'd3, 2'd3, 8'h07, 8'h06}) begin
      errors++; $display("FAIL mem_wait_flush got %h exp %h", {st_a, st_b, ctl_a, ctl_b}, {2'd3, 2'd3, 8'h07, 8'h06});
    end
    step();
    checks++;
    if ({st_a, ctl_a} !== 10'h000) begin errors++; $display("FAIL mem_wait_done got %h exp 000", {st_a, ctl_a}); end
`ifdef HAZARD_PERF_EN
    checks++;
    if ({wait_cnt_a, flush_cnt_a} !== {PERF_W'(4), PERF_W'(1)}) begin
      errors++; $display("FAIL wait_flush_cnt got %0d/%0d exp 4/1", wait_cnt_a, flush_cnt_a);
    end
`endif
  endtask

  task automatic test_redirect_load_use();
    logic [3:0] exp;
    idle(); redirect = 1'b1; x_dst = 5'd4; x_reg_write = 1'b1; x_mem_read = 1'b1; d_rs_a = 5'd4;
    @(negedge clk);
    checks++;
    if ({st_a, ctl_a, ctl_b} !== 18'h0) begin errors++; $display("FAIL redirect_drops_load_use got %h exp 0", {st_a, ctl_a, ctl_b}); end
    step();
    idle(); x_dst = 5'd5; x_reg_write = 1'b1; d_rs_a = 5'd5;
    exp_q.push_back(4'b0000);
    @(negedge clk);
    checks++;
    if ({st_a, st_b, ctl_a, ctl_b} !== {2'd3, 2'd3, 8'h07, 8'h06}) begin
      errors++; $display("FAIL flush_depth got %h exp %h", {st_a, st_b, ctl_a, ctl_b}, {2'd3, 2'd3, 8'h07, 8'h06});
    end
    step();
    exp = exp_q.pop_front();
    checks++;
    if ({st_a, fwd_rs_a, fwd_rt_a, fwd_rs_b, fwd_rt_b} !== {2'd0, exp, exp}) begin
      errors++; $display("FAIL flush_fwd_forced got %b exp %b", {st_a, fwd_rs_a, fwd_rt_a, fwd_rs_b, fwd_rt_b}, {2'd0, exp, exp});
    end
    exp_q.push_back(4'b0100);
    @(negedge clk);
    checks++;
    if ({ctl_a, ctl_b} !== 16'h0) begin errors++; $display("FAIL flush_one_cycle got %h exp 0000", {ctl_a, ctl_b}); end
    step();
    exp = exp_q.pop_front();
    checks++;
    if ({fwd_rs_a, fwd_rt_a} !== exp) begin errors++; $display("FAIL post_flush_fwd got %b exp %b", {fwd_rs_a, fwd_rt_a}, exp); end
`ifdef HAZARD_PERF_EN
    checks++;
    if ({stall_cnt_b, flush_cnt_b} !== {PERF_W'(1), PERF_W'(2)}) begin
      errors++; $display("FAIL redirect_cnt got %0d/%0d exp 1/2", stall_cnt_b, flush_cnt_b);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    idle(); m_mem_req = 1'b1; mem_ready = 1'b0; d_rs_a = 5'd2; m_dst = 5'd2; m_reg_write = 1'b1;
    step();
    checks++;
    if (st_a !== 2'd2) begin errors++; $display("FAIL enter_wait got %0d exp 2", st_a); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({st_a, st_b, ctl_a, ctl_b, fwd_rs_a, fwd_rt_a} !== {2'd0, 2'd0, 8'h07, 8'h07, 4'h0}) begin
      errors++; $display("FAIL async_reset got %h exp %h", {st_a, st_b, ctl_a, ctl_b, fwd_rs_a, fwd_rt_a}, {2'd0, 2'd0, 8'h07, 8'h07, 4'h0});
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if ({stall_cnt_a, flush_cnt_a, wait_cnt_a} !== '0) begin errors++; $display("FAIL cnt_reset got %h exp 0", {stall_cnt_a, flush_cnt_a, wait_cnt_a}); end
`endif
    step();
    idle();
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++;
    if ({st_a, fwd_rs_a, fwd_rt_a, ctl_a} !== 14'h0) begin
      errors++; $display("FAIL after_release got %h exp 0", {st_a, fwd_rs_a, fwd_rt_a, ctl_a});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fwd_directed();
    test_fwd_random();
    test_load_use();
    test_mem_wait();
    test_redirect_load_use();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
